// File: rtl/nios_system_nios2_qsys_0_cpu_oci_dct_monitor_pkg.sv
// Shared types and constants for the DCT trace capture monitor.
package nios_system_nios2_qsys_0_cpu_oci_dct_monitor_pkg;

  // Monitor FSM states; encodings are fixed so software/debug views agree.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } dct_state_e;

  // Width of the lost-word counter.
  localparam int DROP_CNT_WIDTH = 16;

  // Per-cycle FIFO status bundle passed from storage to the control FSM.
  typedef struct packed {
    logic empty;  // no entries held
    logic lost;   // an incoming word was discarded or overwrote the oldest
  } fifo_stat_t;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nios_system_nios2_qsys_0_cpu_oci_dct_fifo.sv
// Capture FIFO: power-of-two depth, optional overwrite-oldest when full,
// combinational head read. Storage is not reset; only pointers/count are.
module nios_system_nios2_qsys_0_cpu_oci_dct_fifo
  import nios_system_nios2_qsys_0_cpu_oci_dct_monitor_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill,
  output fifo_stat_t               stat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q,  cnt_d;

  logic full, empty, do_pop, do_wr, overwrite, lost;

  // Decide push/pop/overwrite and next pointer/count values.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    do_pop    = rd_en && !empty;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    lost      = wr_en && full && !do_pop;
    overwrite = lost && (WRAP != 0);
    do_wr     = wr_en && (!full || do_pop || (WRAP != 0));

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr)                wptr_d = wptr_q + 1'b1;
    if (do_pop || overwrite)  rptr_d = rptr_q + 1'b1;
    // Overwrite keeps occupancy pinned at DEPTH.
    if (do_wr && !overwrite && !do_pop)  cnt_d = cnt_q + 1'b1;
    else if (!do_wr && do_pop)           cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rptr_q];
  assign fill       = cnt_q;
  assign stat.empty = empty;
  assign stat.lost  = lost;

endmodule

// File: rtl/nios_system_nios2_qsys_0_cpu_oci_dct_monitor.sv
// DCT trace monitor: captures qualified trace words until the test ends,
// then drains them through a ready/valid port, then parks in DONE.
module nios_system_nios2_qsys_0_cpu_oci_dct_monitor
  import nios_system_nios2_qsys_0_cpu_oci_dct_monitor_pkg::*;
#(
  parameter int DCT_WIDTH   = 30,
  parameter int COUNT_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int WRAP_MODE   = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DCT_WIDTH-1:0]                 dct_buffer,
  input  logic [COUNT_WIDTH-1:0]               dct_count,
  input  logic                                 dct_valid,
  input  logic                                 test_ending,
  input  logic                                 test_has_ended,
  input  logic                                 rd_ready,
  output logic                                 rd_valid,
  output logic [DCT_WIDTH+COUNT_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]               fill_level,
  output logic                                 overflow,
  output logic [DROP_CNT_WIDTH-1:0]            drop_count,
  output logic                                 done
);

  localparam int W = DCT_WIDTH + COUNT_WIDTH;

  dct_state_e                state_q, state_d;
  logic                      ovf_q, ovf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic       word_ok, capturing, wr_en, rd_en;
  fifo_stat_t fstat;

  nios_system_nios2_qsys_0_cpu_oci_dct_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .WRAP  (WRAP_MODE)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data ({dct_count, dct_buffer}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .fill    (fill_level),
    .stat    (fstat)
  );

  // Next-state, write/read enables and loss bookkeeping.
  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    // Zero-count words carry no trace slots; they are neither stored nor lost.
    word_ok   = dct_valid && (dct_count != '0);
    capturing = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);
    wr_en     = capturing && word_ok;
    rd_valid  = (state_q == ST_DRAIN) && !fstat.empty;
    rd_en     = rd_valid && rd_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (test_ending)  state_d = ST_DRAIN;
        else if (word_ok) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Uses current occupancy: DONE follows the cycle the FIFO is seen empty.
        if (fstat.empty && test_has_ended) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (fstat.lost) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc(drop_q);
    end
  end

  // State and sticky status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_cpu_oci_dct_monitor.sv
// Bench: two monitors (drop-newest and overwrite-oldest) share stimulus and
// are checked every cycle against a list-based behavioural model, plus
// literal expectations for the directed scenarios.
module tb_nios_system_nios2_qsys_0_cpu_oci_dct_monitor;

  localparam int DW = 30, CW = 4, DEPTH = 16, W = DW + CW;
  localparam int M_IDLE = 0, M_CAPT = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;
  logic          dct_valid = 1'b0, test_ending = 1'b0, test_has_ended = 1'b0, rd_ready = 1'b0;

  logic         rdv [2];
  logic [W-1:0] rdd [2];
  logic [4:0]   fl  [2];
  logic         ov  [2];
  logic [15:0]  dc  [2];
  logic         dn  [2];

  always #5 clk = ~clk;

  nios_system_nios2_qsys_0_cpu_oci_dct_monitor #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DEPTH), .WRAP_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
    .rd_valid(rdv[0]), .rd_data(rdd[0]), .fill_level(fl[0]), .overflow(ov[0]), .drop_count(dc[0]), .done(dn[0]));

  nios_system_nios2_qsys_0_cpu_oci_dct_monitor #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DEPTH), .WRAP_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
    .rd_valid(rdv[1]), .rd_data(rdd[1]), .fill_level(fl[1]), .overflow(ov[1]), .drop_count(dc[1]), .done(dn[1]));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (ordered list per instance) -------------
  logic [W-1:0] mbuf [2][DEPTH];
  int           mcnt [2];
  int           mst  [2];
  int           mdrop[2];
  bit           movf [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; mst[m] = M_IDLE; mdrop[m] = 0; movf[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    logic [W-1:0] w;
    bit q;
    int c0;
    w  = {dct_count, dct_buffer};
    q  = dct_valid && (dct_count != 0);
    c0 = mcnt[m];
    if (mst[m] == M_IDLE || mst[m] == M_CAPT) begin
      if (q) begin
        if (mcnt[m] < DEPTH) begin
          mbuf[m][mcnt[m]] = w;
          mcnt[m]++;
        end else begin
          movf[m] = 1;
          if (mdrop[m] < 65535) mdrop[m]++;
          if (m == 1) begin
            for (int i = 0; i < DEPTH-1; i++) mbuf[m][i] = mbuf[m][i+1];
            mbuf[m][DEPTH-1] = w;
          end
        end
      end
      if (test_ending) mst[m] = M_DRAIN;
      else if (q)      mst[m] = M_CAPT;
    end else if (mst[m] == M_DRAIN) begin
      if (c0 > 0 && rd_ready) begin
        for (int i = 0; i < DEPTH-1; i++) mbuf[m][i] = mbuf[m][i+1];
        mcnt[m]--;
      end
      if (c0 == 0 && test_has_ended) mst[m] = M_DONE;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- per-cycle compare + pop log ----------------
  logic [W-1:0] lg0[$], lg1[$];
  logic [W-1:0] prev_d[2];
  bit           prev_stall[2];

  initial begin
    prev_stall[0] = 0; prev_stall[1] = 0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!reset_n) prev_stall[m] = 0;
        else begin
          bit ev;
          ev = (mst[m] == M_DRAIN) && (mcnt[m] > 0);
          chk($sformatf("u%0d.rd_valid", m),   64'(rdv[m]), 64'(ev));
          chk($sformatf("u%0d.fill_level", m), 64'(fl[m]),  64'(mcnt[m]));
          chk($sformatf("u%0d.overflow", m),   64'(ov[m]),  64'(movf[m]));
          chk($sformatf("u%0d.drop_count", m), 64'(dc[m]),  64'(mdrop[m]));
          chk($sformatf("u%0d.done", m),       64'(dn[m]),  64'(mst[m] == M_DONE));
          if (ev) chk($sformatf("u%0d.rd_data", m), 64'(rdd[m]), 64'(mbuf[m][0]));
          if (prev_stall[m] && rdv[m]) chk($sformatf("u%0d.rd_data_stable", m), 64'(rdd[m]), 64'(prev_d[m]));
          prev_stall[m] = rdv[m] && !rd_ready;
          prev_d[m]     = rdd[m];
          if (rdv[m] && rd_ready) begin
            if (m == 0) lg0.push_back(rdd[m]);
            else        lg1.push_back(rdd[m]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    dct_valid = 0; dct_count = '0; dct_buffer = '0;
    test_ending = 0; test_has_ended = 0; rd_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset_n = 0;
    idle_in();
    lg0.delete(); lg1.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic send(input logic [DW-1:0] b, input logic [CW-1:0] c);
    dct_buffer = b; dct_count = c; dct_valid = 1;
    tick();
    dct_valid = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 100 && !(dn[0] && dn[1]); i++) tick();
    chk(nm, 64'({dn[0], dn[1]}), 64'(2'b11));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    // Reset state
    do_reset();
    chk("rst.fill", 64'(fl[0]), 64'(0));
    chk("rst.rd_valid", 64'(rdv[0]), 64'(0));
    chk("rst.done", 64'(dn[1]), 64'(0));

    // S1: five words in, five out in order, clean done
    do_reset();
    for (int k = 1; k <= 5; k++) send(DW'(100 + k), CW'(k));
    test_ending = 1; test_has_ended = 1; rd_ready = 1;
    wait_done("s1.done");
    chk("s1.nreads", 64'(lg0.size()), 64'(5));
    for (int i = 0; i < lg0.size() && i < 5; i++)
      chk($sformatf("s1.word%0d", i), 64'(lg0[i]), 64'({CW'(i + 1), DW'(101 + i)}));
    chk("s1.overflow", 64'(ov[0]), 64'(0));

    // S2: twenty words into a 16-deep FIFO, both full-policies
    do_reset();
    for (int i = 0; i < 20; i++) send(DW'(i), CW'(1));
    chk("s2.u0.fill", 64'(fl[0]), 64'(16));
    chk("s2.u1.fill", 64'(fl[1]), 64'(16));
    chk("s2.u0.drops", 64'(dc[0]), 64'(4));
    chk("s2.u1.drops", 64'(dc[1]), 64'(4));
    chk("s2.u0.ovf", 64'(ov[0]), 64'(1));
    chk("s2.u1.ovf", 64'(ov[1]), 64'(1));
    test_ending = 1; test_has_ended = 1; rd_ready = 1;
    wait_done("s2.done");
    chk("s2.u0.nreads", 64'(lg0.size()), 64'(16));
    chk("s2.u1.nreads", 64'(lg1.size()), 64'(16));
    for (int i = 0; i < lg0.size() && i < 16; i++)
      chk($sformatf("s2.u0.word%0d", i), 64'(lg0[i]), 64'({CW'(1), DW'(i)}));
    for (int i = 0; i < lg1.size() && i < 16; i++)
      chk($sformatf("s2.u1.word%0d", i), 64'(lg1[i]), 64'({CW'(1), DW'(i + 4)}));

    // S3: zero-count words interleaved; only three stored
    do_reset();
    send(DW'(7), 0); send(DW'(11), 3); send(DW'(8), 0); send(DW'(12), 2);
    send(DW'(9), 0); send(DW'(13), 9); send(DW'(10), 0);
    chk("s3.fill", 64'(fl[0]), 64'(3));
    chk("s3.drops", 64'(dc[0]), 64'(0));

    // S4: stalled drain with write pulses; done held off until test_has_ended
    test_ending = 1; test_has_ended = 0;
    for (int i = 0; i < 12; i++) begin
      rd_ready   = (i % 3) != 0;
      dct_valid  = (i % 2) == 1;
      dct_count  = CW'(5);
      dct_buffer = DW'(200 + i);
      tick();
    end
    dct_valid = 0;
    chk("s4.done_early", 64'({dn[0], dn[1]}), 64'(0));
    chk("s4.nreads", 64'(lg0.size()), 64'(3));
    if (lg0.size() == 3) begin
      chk("s4.word0", 64'(lg0[0]), 64'({CW'(3), DW'(11)}));
      chk("s4.word1", 64'(lg0[1]), 64'({CW'(2), DW'(12)}));
      chk("s4.word2", 64'(lg0[2]), 64'({CW'(9), DW'(13)}));
    end
    test_has_ended = 1;
    wait_done("s4.done");

    // S5: asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) send(DW'(50 + i), CW'(4));
    test_ending = 1; rd_ready = 0;
    tick(); tick();
    chk("s5.fill_pre", 64'(fl[0]), 64'(8));
    chk("s5.rdv_pre", 64'(rdv[1]), 64'(1));
    #2 reset_n = 0;
    #1;
    chk("s5.u0.fill_async", 64'(fl[0]), 64'(0));
    chk("s5.u1.fill_async", 64'(fl[1]), 64'(0));
    chk("s5.u0.rdv_async", 64'(rdv[0]), 64'(0));
    chk("s5.u1.rdv_async", 64'(rdv[1]), 64'(0));
    idle_in();
    @(posedge clk); #1;
    reset_n = 1; rd_ready = 1;
    repeat (4) tick();
    chk("s5.rdv_post", 64'({rdv[0], rdv[1]}), 64'(0));
    chk("s5.nreads_post", 64'(lg0.size()), 64'(0));
    send(DW'(77), CW'(6));
    test_ending = 1; test_has_ended = 1;
    wait_done("s5.redone");
    chk("s5.nreads_new", 64'(lg0.size()), 64'(1));

    // S6: randomised traffic checked by the model every cycle
    for (int r = 0; r < 8; r++) begin
      int n, end_at;
      do_reset();
      n      = $urandom_range(5, 40);
      end_at = $urandom_range(3, n);
      for (int i = 0; i < n + 60; i++) begin
        dct_valid      = ($urandom % 4) != 0;
        dct_count      = (($urandom % 3) == 0) ? CW'(0) : CW'($urandom);
        dct_buffer     = DW'($urandom);
        test_ending    = (i >= end_at);
        rd_ready       = ($urandom % 2) != 0;
        test_has_ended = (i >= n + 30) ? 1'b1 : (($urandom % 8) == 0);
        tick();
      end
      rd_ready = 1; test_has_ended = 1; dct_valid = 0;
      wait_done($sformatf("s6.run%0d.done", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
